// File: rtl/snn_load_ctrl.sv
// snn_load_ctrl: unpacks received image bytes into the 1-bit input RAM, runs the SNN core
// and returns the classified digit over UART.
module snn_load_ctrl #(
    parameter int IMG_BITS = 784,
    parameter int ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    input  logic [ADDR_W-1:0] core_addr,
    output logic              core_start,
    input  logic              core_done,
    input  logic [3:0]        core_digit,
    input  logic              tx_rdy,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic [3:0]        result,
    output logic              busy,
    output logic              overrun
);
    typedef enum logic [2:0] {IDLE, SHIFT, WAIT_BYTE, START, RUN, SEND} state_t;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_BITS - 1);
    state_t            state_q;
    logic [7:0]        shreg_q;
    logic [2:0]        bit_cnt_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [3:0]        result_q;
    logic              overrun_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            wr_addr_q <= '0;
            result_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            // bytes are only accepted in IDLE and WAIT_BYTE; anything else is lost
            if (rx_rdy && state_q != IDLE && state_q != WAIT_BYTE) overrun_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    wr_addr_q <= '0;
                    if (rx_rdy) begin
                        shreg_q   <= rx_data;
                        overrun_q <= 1'b0;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg_q   <= shreg_q >> 1;
                    wr_addr_q <= wr_addr_q + 1'b1;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_q <= (wr_addr_q == LAST_ADDR) ? START : WAIT_BYTE;
                end
                WAIT_BYTE: if (rx_rdy) begin
                    shreg_q <= rx_data;
                    state_q <= SHIFT;
                end
                START: state_q <= RUN;
                RUN: if (core_done) begin
                    result_q <= core_digit;
                    state_q  <= SEND;
                end
                SEND: if (tx_rdy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
    assign ram_we     = state_q == SHIFT;
    assign ram_addr   = ram_we ? wr_addr_q : core_addr;
    assign ram_wdata  = ram_we & shreg_q[0];
    assign core_start = state_q == START;
    assign tx_start   = state_q == SEND && tx_rdy;
    assign tx_data    = {4'h0, result_q};
    assign result     = result_q;
    assign busy       = state_q != IDLE;
    assign overrun    = overrun_q;
endmodule

// File: doc/snn_load_ctrl.md
# snn_load_ctrl

Sequencer between the UART front end, the 1024x1 input-image RAM, the SNN inference core and the UART transmitter in the SNN top level. It collects 98 received bytes, unpacks them LSB-first into 784 single-bit RAM writes, and then starts the core. While the core runs it hands RAM address ownership to the core. When the core finishes it captures the classified digit, holds it for the LEDs, and transmits it as one UART byte.

## Interface
Parameters:
- IMG_BITS, 784, number of image bits; must be a multiple of 8 and no greater than 2**ADDR_W
- ADDR_W, 10, RAM address width

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- rx_rdy  in  1  one-cycle pulse from UART receiver: rx_data valid
- rx_data  in  8  received byte
- ram_we  out  1  input RAM write enable
- ram_addr  out  ADDR_W  input RAM address (muxed writer/core)
- ram_wdata  out  1  input RAM write bit
- core_addr  in  ADDR_W  read address driven by SNN core
- core_start  out  1  one-cycle start pulse to core
- core_done  in  1  core completion pulse; core_digit valid in the same cycle
- core_digit  in  4  classified digit 0-9
- tx_rdy  in  1  UART transmitter idle
- tx_start  out  1  one-cycle transmit request
- tx_data  out  8  {4'h0, result}
- result  out  4  last classified digit (drives LEDs)
- busy  out  1  high in every state except IDLE
- overrun  out  1  sticky: byte arrived while not accepting

## Operation
Registers:
- state
- shreg[7:0]
- bit_cnt[2:0]
- wr_addr[ADDR_W-1:0]
- result[3:0]
- overrun

All are reset to 0, and state resets to IDLE.

States and transitions:
- IDLE:
  - Clear wr_addr.
  - On rx_rdy: shreg <= rx_data, clear overrun, go to SHIFT.
- SHIFT (8 cycles per byte):
  - Drive ram_we=1, ram_addr=wr_addr, ram_wdata=shreg[0].
  - Each cycle: shreg >>= 1, wr_addr++, bit_cnt++.
  - When bit_cnt==7: if wr_addr==IMG_BITS-1 go to START, else go to WAIT_BYTE. bit_cnt wraps to 0.
- WAIT_BYTE: on rx_rdy, shreg <= rx_data and go to SHIFT.
- START: core_start=1 for one cycle, then go to RUN.
- RUN: on core_done, result <= core_digit and go to SEND.
- SEND:
  - tx_start = tx_rdy (combinational).
  - When tx_rdy=1, go to IDLE in the same cycle that tx_start is asserted.
  - If tx_rdy=0, hold in SEND indefinitely.

Address and write rules:
- ram_addr = wr_addr in SHIFT, core_addr in all other states.
- ram_we = 0 outside SHIFT; ram_wdata = 0 outside SHIFT.

Data rules:
- tx_data = {4'h0, result} at all times. result persists until the next core_done.
- Bit order: bit k of byte n is written to address 8n+k.
- Exactly IMG_BITS/8 bytes make up one image. Address 783 is the final write; addresses above IMG_BITS-1 are never written.

Boundary conditions:
- rx_rdy in SHIFT, START, RUN or SEND: the byte is dropped and overrun is set. In SHIFT the current byte completes unaffected.
- core_done outside RUN: ignored.
- rx_rdy in the same cycle SEND exits to IDLE: dropped, overrun set. The byte is not treated as the first byte of the next image.
- Reset mid-image: everything returns to reset values. The partial image stays in RAM and the next image overwrites it from address 0.

## Timing
- rx_rdy at cycle T: the first RAM write (bit 0) occurs at T+1, and the last bit of that byte at T+8.
- Final bit write (addr 783) at cycle W: core_start asserts at W+1.
- core_done at cycle D: result updates at D+1, and tx_start asserts at D+1 if tx_rdy=1.
- Back-to-back bytes need at least 9 cycles between rx_rdy pulses; UART at 115200 baud gives roughly 4340 cycles.
- Outputs after reset:
  - ram_we=0, ram_wdata=0, ram_addr=core_addr
  - core_start=0, tx_start=0
  - tx_data=8'h00, result=0
  - busy=0, overrun=0

## Test plan
- Send 98 bytes, byte n = n (byte 1 = 8'h01): RAM addr 8 = 1, addr 9-15 = 0, addr 0-7 = 0. Exactly 784 ram_we cycles. core_start pulses once, one cycle after the addr-783 write.
- Image load, then core_done with core_digit=4'h7 and tx_rdy=1: tx_start is a single pulse at D+1, tx_data=8'h07, result=7, busy=0 at D+2.
- Same as above but tx_rdy=0 for 50 cycles after core_done: state holds in SEND with busy=1 and no tx_start. tx_start fires in the first cycle tx_rdy=1.
- rx_rdy pulse 3 cycles after a prior rx_rdy, and another during RUN: both bytes dropped, overrun=1, RAM contents unchanged. overrun clears on the first byte of the next image.
- Assert rst_n low after 40 bytes: all outputs return to reset values. A full 98-byte image then loads from address 0 and the core starts normally.
- In RUN, drive core_addr=10'h155: ram_addr=10'h155 and ram_we=0. core_done pulses while in IDLE are ignored, with result unchanged and no tx_start.
